rf_host_master: RTL and testbench

//  Initiator for the generated register-file host interface (address/read_en/write_en/write_data,

---
 rtl/rf_host_master.sv | 136 +++++++++++++
 tb/tb_rf_host_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_master.sv
// rtl/rf_host_master.sv - single-outstanding initiator for the register-file host interface
module rf_host_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  res,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    // register-file host side
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read_en,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  invalid_address,
    input  logic                  access_complete
);

    // Counter is sized to hold TIMEOUT_CYCLES; a disabled timeout still keeps a 1-bit counter.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_error_q;
    logic                    rsp_timeout_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [ADDR_WIDTH-1:0]   address_q;
    logic                    read_en_q;
    logic                    write_en_q;
    logic [DATA_WIDTH-1:0]   write_data_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic                    limit_hit;

    // Saturating increment so the counter can never wrap back into range.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // The edge on which the counter reaches the limit is the last edge the enable may stay high.
    assign limit_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    // Access sequencer: IDLE accepts a command, ACCESS drives the RF, RESP holds the result.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            address_q     <= '0;
            read_en_q     <= 1'b0;
            write_en_q    <= 1'b0;
            write_data_q  <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q  <= 1'b0;
                        address_q    <= cmd_addr;
                        write_data_q <= cmd_wdata;
                        read_en_q    <= !cmd_write;
                        write_en_q   <= cmd_write;
                        cnt_q        <= '0;
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_d;
                    if (access_complete) begin
                        // Completion on the limit edge still counts as a normal completion.
                        read_en_q     <= 1'b0;
                        write_en_q    <= 1'b0;
                        rsp_rdata_q   <= (read_en_q && !invalid_address) ? read_data : '0;
                        rsp_error_q   <= invalid_address;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (limit_hit) begin
                        read_en_q     <= 1'b0;
                        write_en_q    <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // A new command is only taken the cycle after the response leaves.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign address     = address_q;
    assign read_en     = read_en_q;
    assign write_en    = write_en_q;
    assign write_data  = write_data_q;

endmodule

// File: tb/tb_rf_host_master.sv
// tb/tb_rf_host_master.sv - directed vector bench for rf_host_master
module tb_rf_host_master;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam int NEVER = 255;
    localparam int NVEC = 9;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [AW-1:0] address;
    logic          read_en;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data = '0;
    logic          invalid_address = 1'b0;
    logic          access_complete = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];
    logic [63:0]   free_cnt = 64'h1000_0000_0000_0000;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        int          lat;
        logic        inv;
        int          hold;
        logic        use_drv;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_en;
    } vec_t;

    vec_t vecs [NVEC];

    rf_host_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .res(res),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .address(address),
        .read_en(read_en),
        .write_en(write_en),
        .write_data(write_data),
        .read_data(read_data),
        .invalid_address(invalid_address),
        .access_complete(access_complete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) free_cnt <= free_cnt + 64'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          en_cnt;
        int          edges;
        int          guard;
        int          exp_edges;
        logic        got_rsp;
        logic        stable_ok;
        logic        hold_ok;
        logic [63:0] drv;
        logic [63:0] p_rdata;

        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;

        en_cnt = 0;
        edges = 1;
        got_rsp = 1'b0;
        stable_ok = 1'b1;
        drv = '0;
        while (!got_rsp && edges < 40) begin
            if (rsp_valid === 1'b1) begin
                got_rsp = 1'b1;
                access_complete = 1'b0;
                invalid_address = 1'b0;
            end else begin
                if (read_en === 1'b1 || write_en === 1'b1) begin
                    en_cnt++;
                    if (read_en !== !v.wr || write_en !== v.wr || address !== v.addr ||
                        (v.wr && write_data !== v.wdata))
                        stable_ok = 1'b0;
                end
                if (v.lat != NEVER && en_cnt == v.lat + 1 && (read_en === 1'b1 || write_en === 1'b1)) begin
                    drv = (v.addr == 8'h02) ? free_cnt : mem[v.addr];
                    access_complete = 1'b1;
                    invalid_address = v.inv;
                    read_data = drv;
                    if (v.wr && !v.inv) mem[v.addr] = write_data;
                end else begin
                    access_complete = 1'b0;
                    invalid_address = 1'b1;
                    read_data = 64'hBADB_ADBA_DBAD_BAD0;
                end
                @(negedge clk);
                edges++;
            end
        end

        exp_edges = v.exp_to ? TO + 1 : v.lat + 2;
        p_rdata = v.use_drv ? drv : v.exp_rdata;
        chk($sformatf("v%0d rsp_valid", idx), got_rsp, 1);
        chk($sformatf("v%0d edges_to_rsp", idx), edges, exp_edges);
        chk($sformatf("v%0d enable_cycles", idx), en_cnt, v.exp_en);
        chk($sformatf("v%0d enable_stable", idx), stable_ok, 1);
        chk($sformatf("v%0d enable_dropped", idx), {read_en, write_en}, 0);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, p_rdata);
        chk($sformatf("v%0d rsp_error", idx), rsp_error, v.exp_err);
        chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);

        hold_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 8'h07;
            access_complete = 1'b1;
            invalid_address = 1'b1;
            read_data = '1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== p_rdata ||
                rsp_error !== v.exp_err || rsp_timeout !== v.exp_to ||
                read_en !== 1'b0 || write_en !== 1'b0)
                hold_ok = 1'b0;
        end
        if (v.hold > 0) chk($sformatf("v%0d hold_stable", idx), hold_ok, 1);

        cmd_valid = 1'b0;
        access_complete = 1'b0;
        invalid_address = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid_after_hs", idx), rsp_valid, 0);
        chk($sformatf("v%0d cmd_ready_after_hs", idx), cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hC000_0000_0000_0000 | 64'(i);

        //           wr    addr   wdata                  lat    inv   hold drv   exp_rdata              err   to    en
        vecs[0] = '{1'b1, 8'h00, 64'd400,               1,     1'b0, 0,   1'b0, 64'd0,                 1'b0, 1'b0, 2};
        vecs[1] = '{1'b0, 8'h00, 64'd0,                 0,     1'b0, 0,   1'b0, 64'd400,               1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 8'h02, 64'd0,                 0,     1'b0, 0,   1'b1, 64'd0,                 1'b0, 1'b0, 1};
        vecs[3] = '{1'b0, 8'h01, 64'd0,                 2,     1'b1, 0,   1'b0, 64'd0,                 1'b1, 1'b0, 3};
        vecs[4] = '{1'b1, 8'h01, 64'h1234,              0,     1'b1, 0,   1'b0, 64'd0,                 1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 8'h03, 64'd0,                 NEVER, 1'b0, 3,   1'b0, 64'd0,                 1'b0, 1'b1, 16};
        vecs[6] = '{1'b0, 8'h00, 64'd0,                 3,     1'b0, 10,  1'b0, 64'd400,               1'b0, 1'b0, 4};
        vecs[7] = '{1'b1, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 15,  1'b0, 0,   1'b0, 64'd0,                 1'b0, 1'b0, 16};
        vecs[8] = '{1'b0, 8'h05, 64'd0,                 14,    1'b0, 2,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 15};

        // Reset state while res is held
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst enables", {read_en, write_en}, 0);
        chk("rst status", {rsp_error, rsp_timeout}, 0);
        chk("rst address", address, 0);
        chk("rst write_data", write_data, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        res = 1'b0;
        @(negedge clk);
        chk("post_rst cmd_ready", cmd_ready, 1);

        // Reset in the middle of a read access drops it without a response
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h04;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid read_en", read_en, 1);
        #2 res = 1'b1;
        #1;
        chk("mid_rst read_en", read_en, 0);
        chk("mid_rst rsp_valid", rsp_valid, 0);
        chk("mid_rst cmd_ready", cmd_ready, 0);
        @(negedge clk);
        res = 1'b0;
        access_complete = 1'b1;
        read_data = 64'h55;
        begin
            logic quiet_ok;
            quiet_ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                access_complete = 1'b0;
                if (rsp_valid !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0) quiet_ok = 1'b0;
            end
            chk("mid_rst no_response", quiet_ok, 1);
        end
        chk("mid_rst cmd_ready_after", cmd_ready, 1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Spurious completion while idle is ignored
        begin
            logic idle_ok;
            idle_ok = 1'b1;
            access_complete = 1'b1;
            invalid_address = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || read_en !== 1'b0 || write_en !== 1'b0)
                    idle_ok = 1'b0;
            end
            access_complete = 1'b0;
            invalid_address = 1'b0;
            chk("idle spurious_complete", idle_ok, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
